ram_fifo_ctrl: RTL and testbench
================================

Name: ram_fifo_ctrl

Overview:
- Sequences one simple dual-port RAM instance (port A write-only, port B read-only, 1-cycle synchronous read) as a first-word-fall-through FIFO for pixel streams.
- Turns valid/ready stream handshakes on both sides into RAM enables and addresses, and tracks occupancy.
- Sits between image-source blocks and line/frame consumers in the Malloc memory layer, one instance per RAM.

Parameters:
- DEPTH, 2048, RAM entries; power of two, at least 4.
- DATA_WIDTH, 12, pixel/data word width.
- ADDR_WIDTH, 11, log2(DEPTH); drives RAM address ports zero-extended to the RAM's address width.

Ports:
- clk  in  1  single clock for all logic and both RAM ports.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  write-side data valid.
- s_ready  out  1  write-side ready.
- s_data  in  DATA_WIDTH  write data.
- m_valid  out  1  read-side data valid.
- m_ready  in  1  read-side ready.
- m_data  out  DATA_WIDTH  read data.
- ram_wea  out  1  RAM write enable.
- ram_ena  out  1  RAM port A enable.
- ram_addra  out  ADDR_WIDTH  RAM write address.
- ram_wr_data  out  DATA_WIDTH  RAM write data.
- ram_enb  out  1  RAM port B enable.
- ram_addrb  out  ADDR_WIDTH  RAM read address.
- ram_rd_data  in  DATA_WIDTH  RAM read data, valid the cycle after ram_enb.
- level  out  ADDR_WIDTH+2  total words held: RAM plus in-flight plus output buffer.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: wr_ptr=0, rd_ptr=0 (ADDR_WIDTH+1 bits each, MSB is the wrap bit), pend=0, buf_cnt=0, m_valid=0, m_data=0, level=0, s_ready=1.
- Write path:
  - s_ready = (ram_cnt != DEPTH), where ram_cnt = wr_ptr - rd_ptr.
  - On push (s_valid && s_ready) in the same cycle: ram_ena=ram_wea=1, ram_addra=wr_ptr[ADDR_WIDTH-1:0], ram_wr_data=s_data; wr_ptr increments at the clock edge.
  - RAM write outputs are combinational from the handshake; otherwise ram_ena=ram_wea=0.
- Read issue:
  - pop = m_valid && m_ready.
  - ram_enb=1 when ram_cnt != 0 && (buf_cnt + pend - pop) < 2.
  - ram_addrb = rd_ptr[ADDR_WIDTH-1:0]; rd_ptr increments on issue; pend <= ram_enb.
- Output buffer:
  - 2-entry register FIFO (skid).
  - When pend=1, ram_rd_data is captured into the buffer.
  - m_valid = (buf_cnt != 0); m_data = head entry, held stable while m_valid && !m_ready.
- Latency: push in cycle 0 into an empty FIFO gives m_valid=1 in cycle 3. With m_ready held high, throughput is 1 word/cycle.
- Read-during-write: empty/issue decisions use registered pointers, so a word is never read in its own write cycle. No same-address collision is possible.
- Full: push blocked while ram_cnt==DEPTH. Capacity is DEPTH+2 words (the output stage adds 2).
- Simultaneous push and pop: both proceed; level unchanged.
- level = ram_cnt + pend + buf_cnt, registered-consistent every cycle.
- Pointer wrap: addresses wrap modulo DEPTH; the wrap bit distinguishes full from empty.
- Reset mid-transfer: all state is cleared immediately and in-flight data is discarded. The RAM contents are irrelevant after reset.

Optional Feature:
- Macro: RAM_FIFO_FLUSH_EN.
- Defined: adds input port flush (1 bit). When flush=1 at a clock edge:
  - wr_ptr, rd_ptr, pend and buf_cnt clear to 0.
  - That cycle, s_ready=0, ram_ena=ram_wea=0 and ram_enb=0.
  - m_valid=0 and level=0 from the next cycle.
  - Flush takes priority over push and pop in the same cycle.
- Undefined: no flush port and no flush logic; behaviour as above.

Decomposition:
- Shared package ram_fifo_pkg:
  - localparam function for pointer width (ADDR_WIDTH+1).
  - Output-buffer depth constant OBUF_DEPTH=2.
  - Typedef for level width.
- Sub-module ram_fifo_obuf: the 2-entry output skid register with capture/pop/count.
- Top holds the pointers, issue logic, RAM port drive and level.

Test Plan:
- Single word (DEPTH=16): push 0x5A3 at cycle 0, m_ready=1 -> m_valid=1 with m_data=0x5A3 at cycle 3, level 1->0 after the pop.
- Fill (DEPTH=16): push 0..17 with m_ready=0 -> s_ready=0 after 18 accepted, level=18, ram_cnt=16; further s_valid is ignored.
- Streaming: continuous push of 0..99 with m_ready=1 -> output 0..99 in order, one per cycle after the 3-cycle fill, level stays at 3 or below.
- Backpressure: random m_ready 50% with random s_valid, 1000 words -> scoreboard exact order, no loss/duplication, m_data stable while stalled.
- Wrap/reset: push/pop 40 words through DEPTH=16 (addresses wrap twice), assert rst mid-stream -> all outputs at reset values in the same cycle, next push reads back correctly.
- Flush (RAM_FIFO_FLUSH_EN): with level=10, pulse flush together with s_valid -> push rejected, next cycle level=0, m_valid=0, next word reads back first.

Source files
------------

// File: rtl/ram_fifo_pkg.sv
// Shared constants and helpers for the RAM-backed FWFT FIFO controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   ptr_width()   - pointer width (address bits plus one wrap bit)
//   level_width() - occupancy counter width (RAM count plus output stage)
//   OBUF_DEPTH    - number of entries in the output skid register
//   obuf_cnt_t    - occupancy type of the output skid register
package ram_fifo_pkg;

  // Output skid register depth; the read issue logic keeps at most this
  // many words in flight plus buffered.
  localparam int OBUF_DEPTH = 2;

  typedef logic [$clog2(OBUF_DEPTH + 1)-1:0] obuf_cnt_t;

  // One extra MSB distinguishes full (MSBs differ) from empty (MSBs equal).
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // Holds values up to DEPTH + OBUF_DEPTH.
  function automatic int level_width(input int addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/ram_fifo_obuf.sv
// Two-entry output skid register that turns 1-cycle RAM reads into a FWFT stream.
// Latency: captured word is presented on m_valid/m_data the cycle after capture.
// Backpressure: head entry holds stable while m_valid && !m_ready; upstream must not over-capture.
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   clr           - synchronous discard of all buffered words
//   cap, cap_data - capture a word returned by the RAM
//   m_ready       - consumer ready; pop = m_valid && m_ready
//   m_valid       - head entry is valid
//   m_data        - head entry
//   cnt           - number of buffered words (0..OBUF_DEPTH)
module ram_fifo_obuf
  import ram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  cap,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output obuf_cnt_t             cnt
);

  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic                  pop;

  assign m_valid = (cnt != '0);
  assign m_data  = head_q;
  assign pop     = m_valid && m_ready;

  // The issue logic upstream guarantees cnt + in-flight never exceeds
  // OBUF_DEPTH, so a capture never arrives while both entries are full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      case ({cap, pop})
        2'b10: begin
          if (cnt == '0) head_q <= cap_data;
          else           tail_q <= cap_data;
          cnt <= cnt + 1'b1;
        end
        2'b01: begin
          head_q <= tail_q;
          cnt    <= cnt - 1'b1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains.
          if (cnt == obuf_cnt_t'(1)) begin
            head_q <= cap_data;
          end else begin
            head_q <= tail_q;
            tail_q <= cap_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Sequences a simple dual-port RAM (A write, B read, 1-cycle read) as a FWFT pixel FIFO.
// Latency: push into an empty FIFO appears on m_valid 3 cycles later; 1 word/cycle streaming.
// Backpressure: s_ready drops when the RAM holds DEPTH words; m_ready stalls hold m_data stable.
//
// Optional feature macro: RAM_FIFO_FLUSH_EN adds a synchronous 'flush' input that
// discards all contents (pointers, in-flight read and output buffer) at the clock edge.
//
// Ports:
//   clk, rst                        - single clock, asynchronous active-high reset
//   flush                           - (RAM_FIFO_FLUSH_EN only) discard everything
//   s_valid, s_ready, s_data        - write-side stream
//   m_valid, m_ready, m_data        - read-side stream
//   ram_wea, ram_ena, ram_addra,
//   ram_wr_data                     - RAM port A (write)
//   ram_enb, ram_addrb, ram_rd_data - RAM port B (read, data valid cycle after ram_enb)
//   level                           - words held: RAM + in-flight read + output buffer
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int DEPTH      = 2048,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef RAM_FIFO_FLUSH_EN
  input  logic                    flush,
`endif
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    ram_wea,
  output logic                    ram_ena,
  output logic [ADDR_WIDTH-1:0]   ram_addra,
  output logic [DATA_WIDTH-1:0]   ram_wr_data,
  output logic                    ram_enb,
  output logic [ADDR_WIDTH-1:0]   ram_addrb,
  input  logic [DATA_WIDTH-1:0]   ram_rd_data,
  output logic [ADDR_WIDTH+1:0]   level
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam int LW = level_width(ADDR_WIDTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [LW-1:0] level_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

  ptr_t      wr_ptr;
  ptr_t      rd_ptr;
  ptr_t      ram_cnt;
  logic      pend;
  obuf_cnt_t buf_cnt;
  logic      flush_i;
  logic      push;
  logic      pop;
  logic      issue;
  logic [2:0] occ;

`ifdef RAM_FIFO_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Wrap-bit arithmetic: the modulo-2^PW difference is the RAM occupancy.
  assign ram_cnt = wr_ptr - rd_ptr;

  // Write side. Decisions use registered pointers only, so a word is never
  // read back in the cycle it is written.
  assign s_ready     = (ram_cnt != DEPTH_P) && !flush_i;
  assign push        = s_valid && s_ready;
  assign ram_ena     = push;
  assign ram_wea     = push;
  assign ram_addra   = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_wr_data = s_data;

  // Read issue: only fetch when the output stage has room for the word once
  // it returns, counting the read already in flight and this cycle's pop.
  assign pop   = m_valid && m_ready;
  assign occ   = 3'(buf_cnt) + 3'(pend) - 3'(pop);
  assign issue = (ram_cnt != '0) && (occ < 3'(OBUF_DEPTH)) && !flush_i;

  assign ram_enb   = issue;
  assign ram_addrb = rd_ptr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      pend   <= 1'b0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      pend   <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      pend <= issue;
    end
  end

  ram_fifo_obuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_obuf (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush_i),
    .cap      (pend),
    .cap_data (ram_rd_data),
    .m_ready  (m_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .cnt      (buf_cnt)
  );

  // Sum of registered terms, so it is consistent with the state every cycle.
  assign level = level_t'(ram_cnt) + level_t'(pend) + level_t'(buf_cnt);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with DEPTH=16 and a behavioural RAM.
// Accepted pushes queue their data; a negedge monitor pops and compares every output word.
// Also checks reset values, first-word latency, fill limit, level bounds, stall stability.
module tb_ram_fifo_ctrl;

  localparam int DW  = 12;
  localparam int AW  = 4;
  localparam int DEP = 16;
  localparam int LW  = AW + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, m_valid, ram_wea, ram_ena, ram_enb;
  logic [DW-1:0] m_data, ram_wr_data;
  logic [DW-1:0] ram_rd_data = '0;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [LW-1:0] level;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] exp_q[$];
  bit            stall_prev = 1'b0;
  logic [DW-1:0] stall_dat  = '0;
  logic [DW-1:0] mem [DEP];

  always #5 clk = ~clk;

  ram_fifo_ctrl #(
    .DEPTH      (DEP),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef RAM_FIFO_FLUSH_EN
    .flush       (flush),
`endif
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .ram_wea     (ram_wea),
    .ram_ena     (ram_ena),
    .ram_addra   (ram_addra),
    .ram_wr_data (ram_wr_data),
    .ram_enb     (ram_enb),
    .ram_addrb   (ram_addrb),
    .ram_rd_data (ram_rd_data),
    .level       (level)
  );

  // Simple dual-port RAM: port A write, port B registered read.
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_wr_data;
    if (ram_enb)            ram_rd_data <= mem[ram_addrb];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compare every delivered word against the scoreboard and check
  // that a stalled head word stays put.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_held", m_valid, 1);
        check("stall_data_held", m_data, stall_dat);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", m_data, 32'hFFFF_FFFF);
        else                   check("out_data", m_data, exp_q.pop_front());
      end
      stall_prev = m_valid && !m_ready && !flush;
      stall_dat  = m_data;
    end
  end

  // One clock cycle of stimulus: drive just after posedge, record an
  // accepted push at the following negedge.
  task automatic drive_cycle(input bit v, input logic [DW-1:0] d, input bit r, output bit acc);
    @(posedge clk);
    #1;
    s_valid = v;
    s_data  = d;
    m_ready = r;
    @(negedge clk);
    acc = v && s_ready;
    if (acc) exp_q.push_back(d);
  endtask

  task automatic drain(input string tag);
    bit acc;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) drive_cycle(1'b0, '0, 1'b1, acc);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    drive_cycle(1'b0, '0, 1'b1, acc);
    check({tag, "_level_zero"}, level, 0);
    check({tag, "_mvalid_zero"}, m_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int acc_total;

    // Reset values while rst is held.
    #3;
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_level", level, 0);
    check("rst_ram_enb", ram_enb, 0);
    check("rst_ram_ena", ram_ena, 0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Single word: m_valid first seen in cycle 3.
    drive_cycle(1'b1, 12'h5A3, 1'b1, acc);
    check("sw_accept", acc, 1);
    check("sw_c0_mvalid", m_valid, 0);
    drive_cycle(1'b0, '0, 1'b1, acc);
    check("sw_c1_mvalid", m_valid, 0);
    check("sw_c1_level", level, 1);
    drive_cycle(1'b0, '0, 1'b1, acc);
    check("sw_c2_mvalid", m_valid, 0);
    check("sw_c2_level", level, 1);
    drive_cycle(1'b0, '0, 1'b1, acc);
    check("sw_c3_mvalid", m_valid, 1);
    check("sw_c3_mdata", m_data, 12'h5A3);
    check("sw_c3_level", level, 1);
    drive_cycle(1'b0, '0, 1'b1, acc);
    check("sw_c4_level", level, 0);
    check("sw_c4_mvalid", m_valid, 0);

    // Fill with the consumer stalled: 18 words fit (16 RAM + 2 buffer).
    acc_total = 0;
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1, DW'(i), 1'b0, acc);
      if (acc) acc_total++;
    end
    check("fill_accepted", acc_total, 18);
    check("fill_s_ready", s_ready, 0);
    check("fill_level", level, 18);
    check("fill_ram_cnt", dut.ram_cnt, 16);
    check("fill_ram_ena", ram_ena, 0);
    drain("fill");

    // Streaming 0..99 with m_ready high.
    acc_total = 0;
    for (int i = 0; i < 100; i++) begin
      drive_cycle(1'b1, DW'(i), 1'b1, acc);
      if (acc) acc_total++;
      if (level > 3) check("stream_level_le3", level, 3);
    end
    check("stream_accepted", acc_total, 100);
    drain("stream");

    // Random backpressure on both sides, 1000 words.
    acc_total = 0;
    for (int c = 0; c < 10000 && acc_total < 1000; c++) begin
      drive_cycle($urandom_range(0, 1) == 1, DW'(acc_total * 37 + 5), $urandom_range(0, 1) == 1, acc);
      if (acc) acc_total++;
    end
    check("bp_accepted", acc_total, 1000);
    drain("bp");

    // Wrap through 40 words, then reset mid-stream.
    for (int i = 0; i < 40; i++) drive_cycle(1'b1, DW'(12'h400 + i), 1'b1, acc);
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, DW'(12'h300 + i), 1'b0, acc);
    #2;
    rst = 1'b1;
    s_valid = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_m_data", m_data, 0);
    check("midrst_level", level, 0);
    check("midrst_s_ready", s_ready, 1);
    check("midrst_ram_enb", ram_enb, 0);
    check("midrst_ram_ena", ram_ena, 0);
    check("midrst_wr_ptr", dut.wr_ptr, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    drive_cycle(1'b1, 12'h7E1, 1'b1, acc);
    check("postrst_accept", acc, 1);
    drain("postrst");

`ifdef RAM_FIFO_FLUSH_EN
    // Flush with 10 words held; concurrent push must be rejected.
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, DW'(12'h200 + i), 1'b0, acc);
    drive_cycle(1'b0, '0, 1'b0, acc);
    check("fl_level_before", level, 10);
    @(posedge clk);
    #1;
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 12'hABC;
    m_ready = 1'b0;
    @(negedge clk);
    check("fl_s_ready", s_ready, 0);
    check("fl_ram_ena", ram_ena, 0);
    check("fl_ram_wea", ram_wea, 0);
    check("fl_ram_enb", ram_enb, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    flush   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check("fl_level_after", level, 0);
    check("fl_mvalid_after", m_valid, 0);
    drive_cycle(1'b1, 12'h0DD, 1'b1, acc);
    check("fl_next_accept", acc, 1);
    drain("flush");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
